// File: rtl/rv32i_imem_arbiter.sv
// Arbitrates a fetch read port and a loader write port onto one instruction memory.
// Define IMEM_ARB_TIMEOUT_EN to add a wait-state abort timer with a sticky o_timeout flag.
module rv32i_imem_arbiter #(
  parameter int unsigned WR_BURST_MAX   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic        i_flush,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_done,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_rd_addr,
  input  logic        i_mem_rd_valid,
  input  logic [31:0] i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_wr_addr,
  output logic [31:0] o_mem_wr_data,
  input  logic        i_mem_wr_valid,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(WR_BURST_MAX);

  state_t      state;
  logic [3:0]  burst_cnt;
  logic        discard;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic grant_wr;
  logic grant_rd;
  logic rd_resp;
  logic wr_resp;
  logic wait_expire;
  logic abort;

  // Write has priority, but a pending read gets the slot once the burst limit is hit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      if (i_wr_req && !(i_rd_req && (burst_cnt == BURST_MAX))) begin
        grant_wr = 1'b1;
      end else if (i_rd_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  assign rd_resp = (state == RD_WAIT) && i_mem_rd_valid;
  assign wr_resp = (state == WR_WAIT) && i_mem_wr_valid;
  assign abort   = wait_expire && !rd_resp && !wr_resp;

  // A flush in the response cycle or any earlier wait cycle swallows the read data.
  assign o_rd_valid    = rd_resp && !discard && !i_flush;
  assign o_rd_data     = o_rd_valid ? i_mem_rd_data : 32'h0;
  assign o_wr_done     = wr_resp;
  assign o_mem_rd_addr = addr_q;
  assign o_mem_wr_addr = addr_q;
  assign o_mem_wr_data = wdata_q;

`ifdef IMEM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_q;

  // Counter sits at zero in IDLE, so it starts from zero on every wait-state entry.
  assign wait_expire = (state != IDLE) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign o_timeout   = timeout_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= 8'd0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wait_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      discard     <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_wr) begin
            state       <= WR_WAIT;
            addr_q      <= i_wr_addr;
            wdata_q     <= i_wr_data;
            o_mem_wr_en <= 1'b1;
            o_busy      <= 1'b1;
            if (!i_rd_req) begin
              burst_cnt <= 4'd0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end else if (grant_rd) begin
            state       <= RD_WAIT;
            addr_q      <= i_rd_addr;
            o_mem_rd_en <= 1'b1;
            o_busy      <= 1'b1;
            burst_cnt   <= 4'd0;
          end
        end

        RD_WAIT: begin
          if (rd_resp || abort) begin
            state       <= IDLE;
            o_mem_rd_en <= 1'b0;
            o_busy      <= 1'b0;
            discard     <= 1'b0;
          end else if (i_flush) begin
            discard <= 1'b1;
          end
        end

        WR_WAIT: begin
          if (wr_resp || abort) begin
            state       <= IDLE;
            o_mem_wr_en <= 1'b0;
            o_busy      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          o_mem_rd_en <= 1'b0;
          o_mem_wr_en <= 1'b0;
          o_busy      <= 1'b0;
          discard     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_imem_arbiter.sv
// Directed bench for rv32i_imem_arbiter: read, contention, flush, async reset and wait-state timeout.
// Build with IMEM_ARB_TIMEOUT_EN defined to exercise the timeout abort instead of the endless wait.
module tb_rv32i_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        flush;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_valid;
  logic        busy;
  logic        timeout;

  logic auto_resp;
  logic rd_valid_drv;
  logic wr_valid_drv;

  int checks = 0;
  int errors = 0;

  // Zero-latency memory while auto_resp is set, otherwise driven by the directed steps.
  assign mem_rd_valid = auto_resp ? mem_rd_en : rd_valid_drv;
  assign mem_wr_valid = auto_resp ? mem_wr_en : wr_valid_drv;

  rv32i_imem_arbiter #(
    .WR_BURST_MAX   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rd_req       (rd_req),
    .i_rd_addr      (rd_addr),
    .i_flush        (flush),
    .o_rd_valid     (rd_valid),
    .o_rd_data      (rd_data),
    .i_wr_req       (wr_req),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .o_wr_done      (wr_done),
    .o_mem_rd_en    (mem_rd_en),
    .o_mem_rd_addr  (mem_rd_addr),
    .i_mem_rd_valid (mem_rd_valid),
    .i_mem_rd_data  (mem_rd_data),
    .o_mem_wr_en    (mem_wr_en),
    .o_mem_wr_addr  (mem_wr_addr),
    .o_mem_wr_data  (mem_wr_data),
    .i_mem_wr_valid (mem_wr_valid),
    .o_busy         (busy),
    .o_timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks follow a #1 settle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic grants [$];
    logic exp_w [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   n_rd_valid;
    int   n_wr_done;
    int   n_both;

    rst_n        = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = 32'h0;
    flush        = 1'b0;
    wr_req       = 1'b0;
    wr_addr      = 32'h0;
    wr_data      = 32'h0;
    mem_rd_data  = 32'h0;
    auto_resp    = 1'b0;
    rd_valid_drv = 1'b0;
    wr_valid_drv = 1'b0;

    // Reset state
    #3;
    check("rst_busy",     busy,        32'd0);
    check("rst_rd_en",    mem_rd_en,   32'd0);
    check("rst_wr_en",    mem_wr_en,   32'd0);
    check("rst_rd_addr",  mem_rd_addr, 32'h0);
    check("rst_timeout",  timeout,     32'd0);
    check("rst_rd_valid", rd_valid,    32'd0);
    check("rst_wr_done",  wr_done,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read only: response on the third wait cycle
    cyc();
    rd_req  = 1'b1;
    rd_addr = 32'h40;
    #1;
    check("rd_idle_busy", busy, 32'd0);
    cyc(); #1;
    check("rd_w1_en",    mem_rd_en,   32'd1);
    check("rd_w1_addr",  mem_rd_addr, 32'h40);
    check("rd_w1_busy",  busy,        32'd1);
    check("rd_w1_valid", rd_valid,    32'd0);
    cyc(); #1;
    check("rd_w2_addr",  mem_rd_addr, 32'h40);
    check("rd_w2_valid", rd_valid,    32'd0);
    cyc();
    rd_valid_drv = 1'b1;
    mem_rd_data  = 32'h0000_0013;
    #1;
    check("rd_w3_valid", rd_valid,    32'd1);
    check("rd_w3_data",  rd_data,     32'h0000_0013);
    check("rd_w3_addr",  mem_rd_addr, 32'h40);
    check("rd_w3_wdone", wr_done,     32'd0);
    cyc();
    rd_valid_drv = 1'b0;
    rd_req       = 1'b0;
    #1;
    check("rd_done_valid", rd_valid,  32'd0);
    check("rd_done_busy",  busy,      32'd0);
    check("rd_done_en",    mem_rd_en, 32'd0);

    // Contention: both requests held, memory answers immediately
    rd_req    = 1'b1;
    rd_addr   = 32'h80;
    wr_req    = 1'b1;
    wr_addr   = 32'h100;
    wr_data   = 32'hA5A5_0000;
    auto_resp = 1'b1;
    n_rd_valid = 0;
    n_wr_done  = 0;
    n_both     = 0;
    for (int i = 0; i < 40 && grants.size() < 10; i++) begin
      cyc(); #1;
      if (mem_wr_en) grants.push_back(1'b1);
      else if (mem_rd_en) grants.push_back(1'b0);
      if (rd_valid) n_rd_valid++;
      if (wr_done) n_wr_done++;
      if (rd_valid && wr_done) n_both++;
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    check("cont_grant_count", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < grants.size()) check($sformatf("cont_grant_%0d_is_wr", i), 32'(grants[i]), 32'(exp_w[i]));
    end
    check("cont_rd_valid_pulses", 32'(n_rd_valid), 32'd2);
    check("cont_wr_done_pulses",  32'(n_wr_done),  32'd8);
    check("cont_both_pulses",     32'(n_both),     32'd0);
    cyc();
    auto_resp = 1'b0;
    #1;
    check("cont_end_busy", busy, 32'd0);

    // Flush one cycle after the grant, response arrives a cycle later
    rd_req  = 1'b1;
    rd_addr = 32'h200;
    cyc();
    flush  = 1'b1;
    rd_req = 1'b0;
    #1;
    check("fl_w1_en",   mem_rd_en,   32'd1);
    check("fl_w1_addr", mem_rd_addr, 32'h200);
    cyc();
    flush        = 1'b0;
    rd_valid_drv = 1'b1;
    mem_rd_data  = 32'hDEAD_BEEF;
    #1;
    check("fl_resp_valid", rd_valid, 32'd0);
    check("fl_resp_data",  rd_data,  32'h0);
    check("fl_resp_busy",  busy,     32'd1);
    cyc();
    rd_valid_drv = 1'b0;
    rd_req       = 1'b1;
    rd_addr      = 32'h204;
    #1;
    check("fl_idle_busy",  busy,      32'd0);
    check("fl_idle_valid", rd_valid,  32'd0);
    cyc();
    rd_valid_drv = 1'b1;
    mem_rd_data  = 32'h0010_0093;
    #1;
    check("fl_next_addr",  mem_rd_addr, 32'h204);
    check("fl_next_valid", rd_valid,    32'd1);
    check("fl_next_data",  rd_data,     32'h0010_0093);
    cyc();
    rd_valid_drv = 1'b0;
    rd_req       = 1'b0;
    // Flush in IDLE does not block the grant; flush coinciding with the response discards it
    flush   = 1'b1;
    rd_req  = 1'b1;
    rd_addr = 32'h208;
    #1;
    check("fl2_idle_busy", busy, 32'd0);
    cyc();
    rd_req       = 1'b0;
    rd_valid_drv = 1'b1;
    mem_rd_data  = 32'h1111_1111;
    #1;
    check("fl2_grant_en",    mem_rd_en, 32'd1);
    check("fl2_coinc_valid", rd_valid,  32'd0);
    cyc();
    rd_valid_drv = 1'b0;
    flush        = 1'b0;
    #1;
    check("fl2_end_busy", busy, 32'd0);

    // Async reset while in WR_WAIT; flush there has no effect
    wr_req  = 1'b1;
    wr_addr = 32'h300;
    wr_data = 32'hCAFE_F00D;
    cyc();
    flush = 1'b1;
    #1;
    check("rw_en",   mem_wr_en,   32'd1);
    check("rw_addr", mem_wr_addr, 32'h300);
    check("rw_data", mem_wr_data, 32'hCAFE_F00D);
    cyc(); #1;
    check("rw_flush_busy", busy,      32'd1);
    check("rw_flush_en",   mem_wr_en, 32'd1);
    rst_n        = 1'b0;
    wr_valid_drv = 1'b1;
    #1;
    check("rw_rst_busy",  busy,        32'd0);
    check("rw_rst_en",    mem_wr_en,   32'd0);
    check("rw_rst_addr",  mem_wr_addr, 32'h0);
    check("rw_rst_data",  mem_wr_data, 32'h0);
    check("rw_rst_wdone", wr_done,     32'd0);
    flush = 1'b0;
    cyc();
    wr_valid_drv = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("rw_rel_busy", busy, 32'd0);
    cyc();
    wr_valid_drv = 1'b1;
    #1;
    check("rw_regrant_en",   mem_wr_en,   32'd1);
    check("rw_regrant_addr", mem_wr_addr, 32'h300);
    check("rw_regrant_done", wr_done,     32'd1);
    check("rw_regrant_rv",   rd_valid,    32'd0);
    cyc();
    wr_valid_drv = 1'b0;
    wr_req       = 1'b0;
    #1;
    check("rw_end_busy",  busy,    32'd0);
    check("rw_end_wdone", wr_done, 32'd0);

    // Memory never answers; the request is dropped during the wait
    rd_req  = 1'b1;
    rd_addr = 32'h400;
    cyc();
    rd_req = 1'b0;
    #1;
    check("to_w1_busy", busy, 32'd1);
    for (int i = 2; i <= 16; i++) cyc();
    #1;
    check("to_w16_busy",    busy,    32'd1);
    check("to_w16_timeout", timeout, 32'd0);
    cyc(); #1;
`ifdef IMEM_ARB_TIMEOUT_EN
    check("to_abort_busy",    busy,      32'd0);
    check("to_abort_en",      mem_rd_en, 32'd0);
    check("to_abort_timeout", timeout,   32'd1);
    check("to_abort_valid",   rd_valid,  32'd0);
    for (int i = 0; i < 5; i++) cyc();
    #1;
    check("to_sticky_timeout", timeout, 32'd1);
    check("to_sticky_busy",    busy,    32'd0);
`else
    check("to_hold_busy",    busy,      32'd1);
    check("to_hold_en",      mem_rd_en, 32'd1);
    check("to_hold_timeout", timeout,   32'd0);
    for (int i = 0; i < 20; i++) cyc();
    #1;
    check("to_hold_busy_late",    busy,     32'd1);
    check("to_hold_timeout_late", timeout,  32'd0);
    check("to_hold_valid_late",   rd_valid, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_imem_arbiter.md
RV32I_IMEM_ARBITER -- requirements
Module: rv32i_imem_arbiter

Interface
REQ-001 SHALL have parameter WR_BURST_MAX, default 4: max consecutive write grants while a read is pending (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: wait-state cycles before abort (range 2..255; used only with IMEM_ARB_TIMEOUT_EN).
REQ-003 SHALL have ports (name, direction, width, meaning):
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rd_req  in  1  fetch read request, held until o_rd_valid.
- i_rd_addr  in  32  fetch read address.
- i_flush  in  1  branch-miss cancel of the fetch read.
- o_rd_valid  out  1  one-cycle pulse; o_rd_data valid.
- o_rd_data  out  32  read data.
- i_wr_req  in  1  loader write request, held until o_wr_done.
- i_wr_addr  in  32  write address.
- i_wr_data  in  32  write data.
- o_wr_done  out  1  one-cycle write-completion pulse.
- o_mem_rd_en  out  1  memory read enable.
- o_mem_rd_addr  out  32  memory read address.
- i_mem_rd_valid  in  1  memory read response.
- i_mem_rd_data  in  32  memory read data.
- o_mem_wr_en  out  1  memory write enable.
- o_mem_wr_addr  out  32  memory write address.
- o_mem_wr_data  out  32  memory write data.
- i_mem_wr_valid  in  1  memory write response.
- o_busy  out  1  high in any non-IDLE state.
- o_timeout  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement FSM states IDLE, RD_WAIT and WR_WAIT.
REQ-005 In IDLE, arbitration SHALL be evaluated every cycle. Write wins when both requests are high, except when the burst counter equals WR_BURST_MAX; then read wins.
REQ-006 On grant, the arbiter SHALL register the requester's address (and write data) at the clock edge. The next state SHALL be RD_WAIT or WR_WAIT.
REQ-007 In RD_WAIT, o_mem_rd_en SHALL be 1 and o_mem_rd_addr SHALL equal the registered address. In WR_WAIT, o_mem_wr_en, o_mem_wr_addr and o_mem_wr_data SHALL be driven from the registered values. All memory enables SHALL be 0 in IDLE.
REQ-008 In RD_WAIT, i_mem_rd_valid SHALL cause:
- o_rd_valid=1 and o_rd_data=i_mem_rd_data in that same cycle (combinational pass-through);
- a return to IDLE at the next edge.
REQ-009 In WR_WAIT, i_mem_wr_valid SHALL cause o_wr_done=1 in that same cycle and a return to IDLE at the next edge.
REQ-010 Minimum grant-to-completion latency SHALL be 1 cycle (request seen in IDLE at edge N, completion pulse during cycle N+1 if the memory responds immediately). There is no back-to-back grant: at least one IDLE cycle between transactions.
REQ-011 The burst counter (4 bits) SHALL:
- increment on each write grant while i_rd_req=1;
- clear on any read grant, and on a write grant while i_rd_req=0;
- saturate at WR_BURST_MAX.
REQ-012 i_flush in RD_WAIT SHALL set a discard flag. The pending response SHALL be consumed without asserting o_rd_valid, and the FSM SHALL return to IDLE on it.
REQ-013 When i_flush and i_mem_rd_valid coincide, the response SHALL be discarded.
REQ-014 i_flush in IDLE or WR_WAIT SHALL have no effect.
REQ-015 The discard flag SHALL clear on leaving RD_WAIT.
REQ-016 Requests dropped before completion SHALL NOT abort an in-flight transaction.
REQ-017 o_rd_valid and o_wr_done SHALL never be high in the same cycle.

Reset
REQ-018 On i_rst_n=0, asynchronously and immediately:
- state=IDLE, burst counter=0, discard flag=0;
- registered address and data =0;
- o_timeout=0;
- all outputs 0.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no completion pulse. After deassertion the arbiter SHALL re-arbitrate from IDLE on the first edge.

Configuration
REQ-020 With macro IMEM_ARB_TIMEOUT_EN defined, an 8-bit wait counter SHALL:
- clear on entry to RD_WAIT or WR_WAIT and increment each cycle there;
- on reaching TIMEOUT_CYCLES without a response, return the FSM to IDLE with no completion pulse and set o_timeout (sticky until reset).
REQ-021 Without IMEM_ARB_TIMEOUT_EN, the wait counter SHALL be absent, o_timeout SHALL be tied to 0, and wait states SHALL last indefinitely.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read only: rd_req, addr 0x40, memory responds after 3 cycles with 0x00000013 -> one o_rd_valid pulse, data 0x00000013, o_mem_rd_addr=0x40 throughout.
- Contention: rd_req and wr_req held high continuously, WR_BURST_MAX=4 -> grant order W,W,W,W,R,W,W,W,W,R.
- Flush: i_flush one cycle after a read grant, response 0xDEADBEEF -> no o_rd_valid, FSM returns to IDLE, next read completes normally.
- Async reset in WR_WAIT: i_rst_n low for 1 cycle -> outputs 0 immediately, no o_wr_done, pending write re-granted after release.
- With IMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory never responds -> after 16 wait cycles FSM in IDLE, o_timeout=1 sticky, no completion pulse. Without the macro -> o_busy remains 1.
